// File: rtl/eth_frame_build.sv
// eth_frame_build
// Assembles one Ethernet/IPv4/UDP frame (preamble+SFD through payload, no FCS)
// into a 32-bit-wide frame RAM, one word per cycle.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   start, payload_len       frame request (sampled in IDLE) and payload bytes
//   dst_mac, src_mac         MAC addresses, first wire byte in the top bits
//   src_ip, dst_ip           IPv4 addresses, first wire byte in the top bits
//   src_port, dst_port       UDP ports
//   pay_addr, pay_data       payload RAM read port (1-cycle read latency)
//   wr_ena, wr_addr, wr_data frame RAM write port
//   last_addr                address of the final word of the last frame
//   busy, done, err          status: in progress / frame complete / rejected
module eth_frame_build #(
  parameter logic [7:0] TTL         = 8'h40,
  parameter int         MAX_PAYLOAD = 1472
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [10:0] payload_len,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  input  logic [31:0] src_ip,
  input  logic [31:0] dst_ip,
  input  logic [15:0] src_port,
  input  logic [15:0] dst_port,
  output logic [8:0]  pay_addr,
  input  logic [31:0] pay_data,
  output logic        wr_ena,
  output logic [8:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic [8:0]  last_addr,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, CSUM, HDR, PAY, DONE} state_t;

  state_t      state, state_nx;
  logic [8:0]  widx, widx_nx;      // CSUM word counter, then frame word index
  logic [10:0] len_q;
  logic [47:0] dmac_q, smac_q;
  logic [31:0] sip_q, dip_q;
  logic [15:0] sport_q, dport_q;
  logic [15:0] ip_id;
  logic [19:0] acc;
  logic [15:0] prev_hi;            // upper half of the previous payload word

  logic        bad_len;
  logic [8:0]  n_words, last_w;
  logic [15:0] total_len, udp_len;
  logic [15:0] csum_word;
  logic [16:0] fold1;
  logic [15:0] fold2, csum;
  logic [63:0][7:0] hb, hbs;
  logic [31:0] hdr_word;
  logic [8:0]  pa_raw, pa_clamp;

  assign bad_len   = (payload_len == 11'd0) || (payload_len[1:0] != 2'b00) ||
                     (int'(payload_len) > MAX_PAYLOAD);
  assign n_words   = len_q[10:2];
  assign last_w    = n_words + 9'd12;
  assign total_len = {5'b0, len_q} + 16'd28;
  assign udp_len   = {5'b0, len_q} + 16'd8;

  // One IPv4 header halfword per CSUM cycle; checksum field counts as zero.
  always_comb begin
    csum_word = 16'h0000;
    case (widx[3:0])
      4'd0: csum_word = 16'h4500;
      4'd1: csum_word = total_len;
      4'd2: csum_word = ip_id;
      4'd3: csum_word = 16'h4000;
      4'd4: csum_word = {TTL, 8'h11};
      4'd6: csum_word = sip_q[31:16];
      4'd7: csum_word = sip_q[15:0];
      4'd8: csum_word = dip_q[31:16];
      4'd9: csum_word = dip_q[15:0];
      default: csum_word = 16'h0000;
    endcase
  end

  // Two end-around-carry folds of the 20-bit sum, then one's complement.
  assign fold1 = {1'b0, acc[15:0]} + {13'b0, acc[19:16]};
  assign fold2 = fold1[15:0] + {15'b0, fold1[16]};
  assign csum  = ~fold2;

  // Header bytes in wire order; bytes 50..63 are padding so the word select
  // below never leaves the array.
  always_comb begin
    hb = '0;
    for (int i = 0; i < 7; i++) hb[i] = 8'h55;
    hb[7] = 8'hD5;
    for (int i = 0; i < 6; i++) begin
      hb[8+i]  = dmac_q[8*(5-i) +: 8];
      hb[14+i] = smac_q[8*(5-i) +: 8];
    end
    hb[20] = 8'h08;            hb[21] = 8'h00;
    hb[22] = 8'h45;            hb[23] = 8'h00;
    hb[24] = total_len[15:8];  hb[25] = total_len[7:0];
    hb[26] = ip_id[15:8];      hb[27] = ip_id[7:0];
    hb[28] = 8'h40;            hb[29] = 8'h00;
    hb[30] = TTL;              hb[31] = 8'h11;
    hb[32] = csum[15:8];       hb[33] = csum[7:0];
    for (int i = 0; i < 4; i++) begin
      hb[34+i] = sip_q[8*(3-i) +: 8];
      hb[38+i] = dip_q[8*(3-i) +: 8];
    end
    hb[42] = sport_q[15:8];    hb[43] = sport_q[7:0];
    hb[44] = dport_q[15:8];    hb[45] = dport_q[7:0];
    hb[46] = udp_len[15:8];    hb[47] = udp_len[7:0];
  end

  // The streamer expects generated bytes nibble-swapped.
  always_comb begin
    for (int i = 0; i < 64; i++) hbs[i] = {hb[i][3:0], hb[i][7:4]};
  end

  assign hdr_word = hbs[{widx[3:0], 2'b00} +: 4];

  // Read address runs one word ahead of the write; hold at the last word.
  assign pa_raw   = widx - 9'd11;
  assign pa_clamp = (pa_raw > n_words - 9'd1) ? n_words - 9'd1 : pa_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      widx      <= '0;
      len_q     <= '0;
      dmac_q    <= '0;
      smac_q    <= '0;
      sip_q     <= '0;
      dip_q     <= '0;
      sport_q   <= '0;
      dport_q   <= '0;
      ip_id     <= '0;
      acc       <= '0;
      prev_hi   <= '0;
      last_addr <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_nx;
      widx  <= widx_nx;
      err   <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (bad_len) err <= 1'b1;
          else begin
            len_q   <= payload_len;
            dmac_q  <= dst_mac;
            smac_q  <= src_mac;
            sip_q   <= src_ip;
            dip_q   <= dst_ip;
            sport_q <= src_port;
            dport_q <= dst_port;
            acc     <= '0;
          end
        end
        CSUM: acc <= acc + {4'b0, csum_word};
        HDR:  prev_hi <= pay_data[31:16];
        PAY: begin
          prev_hi <= pay_data[31:16];
          if (widx == last_w) begin
            last_addr <= widx;
            ip_id     <= ip_id + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    widx_nx  = widx;
    case (state)
      IDLE: begin
        widx_nx = '0;
        if (start && !bad_len) state_nx = CSUM;
      end
      CSUM: begin
        widx_nx = widx + 9'd1;
        if (widx == 9'd9) begin
          state_nx = HDR;
          widx_nx  = '0;
        end
      end
      HDR: begin
        widx_nx = widx + 9'd1;
        if (widx == 9'd12) state_nx = PAY;
      end
      PAY: begin
        widx_nx = widx + 9'd1;
        if (widx == last_w) begin
          state_nx = DONE;
          widx_nx  = '0;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decode from state so an async reset drops them immediately.
  always_comb begin
    wr_ena   = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    pay_addr = '0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      CSUM: busy = 1'b1;
      HDR: begin
        busy    = 1'b1;
        wr_ena  = 1'b1;
        wr_addr = widx;
        wr_data = (widx == 9'd12) ? {pay_data[15:0], hdr_word[15:0]} : hdr_word;
        if (widx >= 9'd11) pay_addr = pa_clamp;
      end
      PAY: begin
        busy     = 1'b1;
        wr_ena   = 1'b1;
        wr_addr  = widx;
        wr_data  = (widx == last_w) ? {16'h0000, prev_hi} : {pay_data[15:0], prev_hi};
        pay_addr = pa_clamp;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule
